// File: rtl/sseg_display_arbiter.sv
// Arbitrates one 4-digit seven-segment driver between temperature, station and fault sources.
// Temperature and station pages rotate round-robin with a blank gap; a fault page preempts them.
module sseg_display_arbiter #(
  parameter int unsigned DWELL_CYCLES = 50000000,
  parameter int unsigned BLANK_CYCLES = 5000000
) (
  input  logic       displayCLK,
  input  logic       displayRSTn,
  input  logic       enable,
  input  logic       tempReq,
  input  logic [7:0] tempData,
  input  logic       stationReq,
  input  logic [7:0] stationData,
  input  logic       faultReq,
  input  logic [7:0] faultData,
  output logic       tempGnt,
  output logic       stationGnt,
  output logic       faultGnt,
  output logic       display,
  output logic [7:0] decimalTemp,
  output logic [1:0] activeSrc
);

  localparam int unsigned DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int unsigned BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  localparam logic [1:0] SRC_NONE    = 2'd0;
  localparam logic [1:0] SRC_TEMP    = 2'd1;
  localparam logic [1:0] SRC_STATION = 2'd2;
  localparam logic [1:0] SRC_FAULT   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BLANK,
    ST_TEMP,
    ST_STATION,
    ST_FAULT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          dwell_restart;
  logic [DW-1:0] dwell_cnt;
  logic [BW-1:0] blank_cnt;
  logic          dwell_done;
  logic          blank_done;
  logic          last_station;
  state_t        rr_pick;

  logic       temp_gnt_nxt;
  logic       station_gnt_nxt;
  logic       fault_gnt_nxt;
  logic       display_nxt;
  logic [7:0] value_nxt;
  logic [1:0] src_nxt;

  assign dwell_done = (dwell_cnt == DW'(DWELL_CYCLES - 1));
  assign blank_done = (blank_cnt == BW'(BLANK_CYCLES - 1));

  // Temp wins unless it was the last one shown and station is also waiting.
  always_comb begin
    rr_pick = ST_IDLE;
    if (tempReq && (last_station || !stationReq)) begin
      rr_pick = ST_TEMP;
    end else if (stationReq) begin
      rr_pick = ST_STATION;
    end
  end

  always_ff @(posedge displayCLK or negedge displayRSTn) begin
    if (!displayRSTn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    dwell_restart = 1'b0;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (faultReq) begin
            state_nxt = ST_FAULT;
          end else if (tempReq || stationReq) begin
            state_nxt = ST_BLANK;
          end
        end
        ST_BLANK: begin
          if (faultReq) begin
            state_nxt = ST_FAULT;
          end else if (blank_done) begin
            state_nxt = rr_pick;
          end
        end
        ST_TEMP: begin
          if (faultReq) begin
            state_nxt = ST_FAULT;
          end else if (!tempReq) begin
            state_nxt = ST_BLANK;
          end else if (dwell_done) begin
            if (stationReq) begin
              state_nxt = ST_BLANK;
            end else begin
              dwell_restart = 1'b1;
            end
          end
        end
        ST_STATION: begin
          if (faultReq) begin
            state_nxt = ST_FAULT;
          end else if (!stationReq) begin
            state_nxt = ST_BLANK;
          end else if (dwell_done) begin
            if (tempReq) begin
              state_nxt = ST_BLANK;
            end else begin
              dwell_restart = 1'b1;
            end
          end
        end
        ST_FAULT: begin
          if (dwell_done && !faultReq) begin
            state_nxt = ST_BLANK;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output values for the state being entered, so the registered outputs line up with it.
  always_comb begin
    temp_gnt_nxt    = 1'b0;
    station_gnt_nxt = 1'b0;
    fault_gnt_nxt   = 1'b0;
    display_nxt     = 1'b0;
    value_nxt       = 8'h00;
    src_nxt         = SRC_NONE;
    case (state_nxt)
      ST_TEMP: begin
        temp_gnt_nxt = 1'b1;
        display_nxt  = 1'b1;
        value_nxt    = tempData;
        src_nxt      = SRC_TEMP;
      end
      ST_STATION: begin
        station_gnt_nxt = 1'b1;
        display_nxt     = 1'b1;
        value_nxt       = stationData;
        src_nxt         = SRC_STATION;
      end
      ST_FAULT: begin
        fault_gnt_nxt = 1'b1;
        display_nxt   = 1'b1;
        value_nxt     = faultData;
        src_nxt       = SRC_FAULT;
      end
      default: begin
        display_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge displayCLK or negedge displayRSTn) begin
    if (!displayRSTn) begin
      tempGnt     <= 1'b0;
      stationGnt  <= 1'b0;
      faultGnt    <= 1'b0;
      display     <= 1'b0;
      decimalTemp <= 8'h00;
      activeSrc   <= SRC_NONE;
    end else begin
      tempGnt     <= temp_gnt_nxt;
      stationGnt  <= station_gnt_nxt;
      faultGnt    <= fault_gnt_nxt;
      display     <= display_nxt;
      decimalTemp <= value_nxt;
      activeSrc   <= src_nxt;
    end
  end

  // Saturating dwell/blank counters, cleared on every state entry or page restart.
  always_ff @(posedge displayCLK or negedge displayRSTn) begin
    if (!displayRSTn) begin
      dwell_cnt <= '0;
      blank_cnt <= '0;
    end else begin
      if ((state_nxt != state) || dwell_restart) begin
        dwell_cnt <= '0;
      end else if (!dwell_done) begin
        dwell_cnt <= dwell_cnt + DW'(1);
      end
      if (state_nxt != state) begin
        blank_cnt <= '0;
      end else if (!blank_done) begin
        blank_cnt <= blank_cnt + BW'(1);
      end
    end
  end

  // Remembers the last non-fault page; fault pages leave it untouched.
  always_ff @(posedge displayCLK or negedge displayRSTn) begin
    if (!displayRSTn) begin
      last_station <= 1'b1;
    end else if (state_nxt == ST_TEMP) begin
      last_station <= 1'b0;
    end else if (state_nxt == ST_STATION) begin
      last_station <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sseg_display_arbiter.sv
// Directed bench for sseg_display_arbiter with DWELL_CYCLES=4, BLANK_CYCLES=2.
module tb_sseg_display_arbiter;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       temp_req;
  logic [7:0] temp_data;
  logic       station_req;
  logic [7:0] station_data;
  logic       fault_req;
  logic [7:0] fault_data;
  logic       temp_gnt;
  logic       station_gnt;
  logic       fault_gnt;
  logic       display;
  logic [7:0] decimal_temp;
  logic [1:0] active_src;

  int checks   = 0;
  int failures = 0;

  logic [13:0] obs;
  assign obs = {temp_gnt, station_gnt, fault_gnt, display, active_src, decimal_temp};

  sseg_display_arbiter #(
    .DWELL_CYCLES(4),
    .BLANK_CYCLES(2)
  ) dut (
    .displayCLK (clk),
    .displayRSTn(rst_n),
    .enable     (enable),
    .tempReq    (temp_req),
    .tempData   (temp_data),
    .stationReq (station_req),
    .stationData(station_data),
    .faultReq   (fault_req),
    .faultData  (fault_data),
    .tempGnt    (temp_gnt),
    .stationGnt (station_gnt),
    .faultGnt   (fault_gnt),
    .display    (display),
    .decimalTemp(decimal_temp),
    .activeSrc  (active_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vector for a page code (0 none, 1 temp, 2 station, 3 fault).
  function automatic logic [13:0] exp_vec(input int unsigned code, input logic [7:0] data);
    logic [2:0] g;
    g = (code == 1) ? 3'b100 : (code == 2) ? 3'b010 : (code == 3) ? 3'b001 : 3'b000;
    return {g, 1'(code != 0), 2'(code), (code == 0) ? 8'h00 : data};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    enable       = 1'b0;
    temp_req     = 1'b0;
    station_req  = 1'b0;
    fault_req    = 1'b0;
    temp_data    = 8'h00;
    station_data = 8'h00;
    fault_data   = 8'h00;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    step();
    checks++;
    if (obs !== 14'h0) begin
      failures++;
      $display("FAIL reset_hold: got %h expected %h", obs, 14'h0);
    end
    rst_n  = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (obs !== 14'h0) begin
        failures++;
        $display("FAIL idle_no_req cycle %0d: got %h expected %h", i, obs, 14'h0);
      end
    end
  endtask

  task automatic test_rotation();
    int unsigned codes [0:14];
    logic [7:0]  d;
    codes = '{0, 0, 1, 1, 1, 1, 0, 0, 2, 2, 2, 2, 0, 0, 1};
    do_reset();
    enable       = 1'b1;
    temp_req     = 1'b1;
    station_req  = 1'b1;
    temp_data    = 8'h23;
    station_data = 8'h07;
    for (int i = 0; i < 15; i++) begin
      step();
      d = (codes[i] == 1) ? 8'h23 : 8'h07;
      checks++;
      if (obs !== exp_vec(codes[i], d)) begin
        failures++;
        $display("FAIL rotation step %0d: got %h expected %h", i + 1, obs, exp_vec(codes[i], d));
      end
    end
  endtask

  task automatic test_single_source();
    int unsigned codes [0:11];
    logic [7:0]  d;
    codes = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    do_reset();
    enable    = 1'b1;
    temp_req  = 1'b1;
    temp_data = 8'h10;
    for (int i = 0; i < 12; i++) begin
      step();
      d = (i < 4) ? 8'h10 : 8'h11;
      checks++;
      if (obs !== exp_vec(codes[i], d)) begin
        failures++;
        $display("FAIL single_source step %0d: got %h expected %h", i + 1, obs, exp_vec(codes[i], d));
      end
      if (i == 3) temp_data = 8'h11;
    end
  endtask

  task automatic test_fault_preempt();
    int unsigned codes [0:16];
    logic [7:0]  d;
    codes = '{0, 0, 1, 1, 1, 1, 0, 0, 2, 2, 3, 3, 3, 3, 0, 0, 1};
    do_reset();
    enable       = 1'b1;
    temp_req     = 1'b1;
    station_req  = 1'b1;
    temp_data    = 8'h23;
    station_data = 8'h07;
    fault_data   = 8'hE1;
    for (int i = 0; i < 17; i++) begin
      step();
      d = (codes[i] == 1) ? 8'h23 : (codes[i] == 2) ? 8'h07 : 8'hE1;
      checks++;
      if (obs !== exp_vec(codes[i], d)) begin
        failures++;
        $display("FAIL fault_preempt step %0d: got %h expected %h", i + 1, obs, exp_vec(codes[i], d));
      end
      if (i == 9)  fault_req = 1'b1;
      if (i == 10) fault_req = 1'b0;
    end
  endtask

  task automatic test_drop_and_enable();
    int unsigned codes [0:8];
    logic [7:0]  d;
    codes = '{0, 0, 1, 1, 0, 0, 2, 2, 0};
    do_reset();
    enable       = 1'b1;
    temp_req     = 1'b1;
    station_req  = 1'b1;
    temp_data    = 8'h23;
    station_data = 8'h07;
    for (int i = 0; i < 9; i++) begin
      step();
      d = (codes[i] == 1) ? 8'h23 : 8'h07;
      checks++;
      if (obs !== exp_vec(codes[i], d)) begin
        failures++;
        $display("FAIL drop_enable step %0d: got %h expected %h", i + 1, obs, exp_vec(codes[i], d));
      end
      if (i == 3) temp_req = 1'b0;
      if (i == 7) enable = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    enable     = 1'b1;
    fault_req  = 1'b1;
    fault_data = 8'hE1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (obs !== exp_vec(3, 8'hE1)) begin
        failures++;
        $display("FAIL async_fault_page step %0d: got %h expected %h", i + 1, obs, exp_vec(3, 8'hE1));
      end
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 14'h0) begin
      failures++;
      $display("FAIL async_clear: got %h expected %h", obs, 14'h0);
    end
    step();
    checks++;
    if (obs !== 14'h0) begin
      failures++;
      $display("FAIL async_hold: got %h expected %h", obs, 14'h0);
    end
    #2;
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== 14'h0) begin
      failures++;
      $display("FAIL async_release: got %h expected %h", obs, 14'h0);
    end
    step();
    checks++;
    if (obs !== exp_vec(3, 8'hE1)) begin
      failures++;
      $display("FAIL async_first_edge: got %h expected %h", obs, exp_vec(3, 8'hE1));
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    enable       = 1'b0;
    temp_req     = 1'b0;
    station_req  = 1'b0;
    fault_req    = 1'b0;
    temp_data    = 8'h00;
    station_data = 8'h00;
    fault_data   = 8'h00;
    test_reset();
    test_rotation();
    test_single_source();
    test_fault_preempt();
    test_drop_and_enable();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
